led_timer_bank: RTL and testbench
=================================

Name: led_timer_bank

Overview:
Parametrised multi-channel LED on-timer bank driving the board LEDR outputs.
- Each channel lights its LED for a per-request duration in milliseconds.
- Supports retrigger policy, per-channel and global cancel, request accept/reject status and a live active-channel count.
- Sits between event-detect logic (index + request strobe) and the LEDR pins.

Parameters:
- CLK_PERIOD_NS, 50, clock period in ns.
- LED_COUNT, 18, number of channels/LEDs (1..32).
- IDX_W, 5, width of led_index; must satisfy 2**IDX_W >= LED_COUNT.
- TICK_MS, 1, tick period in ms; localparam TICK_CYCLES = TICK_MS*1_000_000/CLK_PERIOD_NS, must be >= 1.
- DUR_W, 16, width of the duration field and of each channel counter, in ticks.
- DEFAULT_TICKS, 5000, duration loaded when led_dur is 0.
- RETRIGGER, 0, policy for a request to an active channel: 0 = reject, 1 = reload the new duration.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- led_index  in  IDX_W  target channel for request/cancel.
- led_request  in  1  single-cycle strobe: start timer on led_index.
- led_dur  in  DUR_W  duration in ticks; 0 selects DEFAULT_TICKS.
- led_cancel  in  1  strobe: clear channel led_index.
- cancel_all  in  1  strobe: clear all channels.
- req_accepted  out  1  registered pulse, one cycle after an accepted request.
- req_rejected  out  1  registered pulse, one cycle after a rejected request.
- active_count  out  $clog2(LED_COUNT+1)  number of channels with a nonzero counter (registered).
- LEDR  out  LED_COUNT  LEDR[k] = 1 while counter[k] != 0.
- led_blink  in  1  only present with LED_BLINK_EN; see Optional Feature.

Behaviour:
- Reset (synchronous, on clk edge with rst=1): all counters 0, prescaler 0, req_* 0, active_count 0, LEDR 0; any in-flight timer is aborted.
- Prescaler:
  - Counts 0..TICK_CYCLES-1.
  - tick = 1 for one cycle when it wraps.
  - Free-running; not synchronised to requests.
- Per channel, each cycle, in this priority order:
  1. cancel_all, or led_cancel with led_index==k: counter <= 0.
  2. Accepted request on k: counter <= (led_dur==0 ? DEFAULT_TICKS : led_dur).
  3. tick and counter != 0: counter <= counter-1.
  4. Otherwise hold.
- Accept rules for a request:
  - Rejected if led_index >= LED_COUNT.
  - Rejected if cancel_all is high, or led_cancel is high for the same index (cancel wins).
  - Accepted if the channel is idle (counter==0).
  - Accepted if the channel is expiring this cycle (counter==1 and tick).
  - Otherwise accepted only if RETRIGGER==1, else rejected.
- Latency: LEDR[k] rises on the edge that loads the counter, so it is visible 1 cycle after the strobe.
- On-time: between (D-1)*TICK_CYCLES+1 and D*TICK_CYCLES cycles for loaded value D.
- Counter never wraps: decrement happens only when the counter is nonzero.
- The led_dur value is used as-is (DUR_W bits); no saturation needed.
- led_request and led_cancel for different indices in the same cycle both take effect.
- active_count is the popcount of (counter != 0) registered, so it lags LEDR by 1 cycle.

Optional Feature:
- Macro LED_BLINK_EN.
- When defined:
  - Adds the led_blink port and one blink flag per channel, latched on accept and cleared on cancel or expiry.
  - A global phase bit toggles every 250 ticks; reset sets it to 0.
  - For blinking channels, LEDR[k] = (counter[k] != 0) & phase.
- When undefined:
  - No port, no flags.
  - LEDR is the solid on/off behaviour above.

Decomposition:
- Package led_timer_pkg holds:
  - function tick_cycles(clk_period_ns, tick_ms)
  - BLINK_HALF_TICKS = 250
  - DEFAULT_TICKS default
  - enum retrig_e {RETRIG_IGNORE=0, RETRIG_RELOAD=1}
- Sub-module led_tick_gen (prescaler producing the tick strobe) is natural.
- Channel counters stay in a generate loop in the top module.

Test Plan:
All scenarios use CLK_PERIOD_NS=1_000_000, TICK_MS=1 (TICK_CYCLES=1), LED_COUNT=18.
1. Reset then request idx 3, dur 4 -> req_accepted pulse; LEDR[3]=1 for exactly 4 cycles after the strobe; active_count goes 1 then 0.
2. RETRIGGER=0: idx 5 dur 10, re-request at cycle 3 with dur 10 -> req_rejected; LED off 10 cycles after the first strobe. With RETRIGGER=1 -> accepted; LED off 13 cycles after the first strobe.
3. Request idx 20 -> req_rejected; LEDR unchanged. Request dur 0 with DEFAULT_TICKS=8 -> on for 8 cycles.
4. Request and led_cancel on idx 2 in the same cycle -> rejected; LEDR[2] stays 0. cancel_all while 6 channels are active -> LEDR=0 next cycle; active_count=0 one cycle later.
5. idx 7 dur 1, re-request on the expiry cycle (counter==1, tick) with dur 3, RETRIGGER=0 -> accepted; LEDR[7] stays high with no gap.
6. rst asserted mid-timer on 4 channels -> all LEDR 0 after that edge, req_* 0. LED_BLINK_EN build: blink request dur 1000 -> LEDR toggles at 250-cycle intervals until expiry.

Source files
------------

// File: rtl/led_timer_pkg.sv
// Shared constants and helpers for the LED on-timer bank.
package led_timer_pkg;

   localparam int BLINK_HALF_TICKS   = 250;
   localparam int DEFAULT_TICKS_DFLT = 5000;

   typedef enum logic {
      RETRIG_IGNORE = 1'b0,
      RETRIG_RELOAD = 1'b1
   } retrig_e;

   function automatic int tick_cycles(input longint clk_period_ns, input longint tick_ms);
      return int'((tick_ms * 64'd1_000_000) / clk_period_ns);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: tick_o is high for one cycle every TICK_CYCLES clocks.
module led_tick_gen #(
   parameter int TICK_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam int               CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/led_timer_bank.sv
// Multi-channel LED on-timer bank. Optional blink mode is enabled with the LED_BLINK_EN macro.
module led_timer_bank
   import led_timer_pkg::*;
#(
   parameter int CLK_PERIOD_NS = 50,
   parameter int LED_COUNT     = 18,
   parameter int IDX_W         = 5,
   parameter int TICK_MS       = 1,
   parameter int DUR_W         = 16,
   parameter int DEFAULT_TICKS = DEFAULT_TICKS_DFLT,
   parameter int RETRIGGER     = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [IDX_W-1:0]               led_index,
   input  logic                           led_request,
   input  logic [DUR_W-1:0]               led_dur,
   input  logic                           led_cancel,
   input  logic                           cancel_all,
   output logic                           req_accepted,
   output logic                           req_rejected,
   output logic [$clog2(LED_COUNT+1)-1:0] active_count,
`ifdef LED_BLINK_EN
   input  logic                           led_blink,
`endif
   output logic [LED_COUNT-1:0]           LEDR
);

   localparam int               TICK_CYCLES   = tick_cycles(CLK_PERIOD_NS, TICK_MS);
   localparam int               ACT_W         = $clog2(LED_COUNT + 1);
   localparam logic [DUR_W-1:0] DEF_DUR       = DUR_W'(DEFAULT_TICKS);
   localparam logic [DUR_W-1:0] ONE           = DUR_W'(1);
   localparam retrig_e          RETRIG_POLICY = retrig_e'(RETRIGGER[0]);

   logic                 tick;
   logic [DUR_W-1:0]     load_dur;
   logic [LED_COUNT-1:0] live;
   logic [LED_COUNT-1:0] accept;
   logic                 req_accepted_q, req_rejected_q;
   logic [ACT_W-1:0]     active_q, active_d;

   led_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   assign load_dur = (led_dur == '0) ? DEF_DUR : led_dur;

`ifdef LED_BLINK_EN
   logic [7:0] ph_cnt_q, ph_cnt_d;
   logic       phase_q, phase_d;

   always_comb begin
      ph_cnt_d = ph_cnt_q;
      phase_d  = phase_q;
      if (tick) begin
         if (ph_cnt_q == 8'(BLINK_HALF_TICKS - 1)) begin
            ph_cnt_d = '0;
            phase_d  = ~phase_q;
         end else begin
            ph_cnt_d = ph_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ph_cnt_q <= '0;
         phase_q  <= 1'b0;
      end else begin
         ph_cnt_q <= ph_cnt_d;
         phase_q  <= phase_d;
      end
   end
`endif

   for (genvar k = 0; k < LED_COUNT; k++) begin : g_ch
      logic [DUR_W-1:0] cnt_q, cnt_d;
      logic             hit, kill, can_take;

      assign hit  = led_request && (led_index == IDX_W'(k));
      assign kill = cancel_all || (led_cancel && (led_index == IDX_W'(k)));
      // A channel on its last tick counts as free, so back-to-back requests leave no dark gap.
      assign can_take  = (cnt_q == '0) || ((cnt_q == ONE) && tick) ||
                         (RETRIG_POLICY == RETRIG_RELOAD);
      assign accept[k] = hit && !kill && can_take;

      // NOTE: every always_comb output gets a default first so no latch is inferred.
      always_comb begin
         cnt_d = cnt_q;
         if (kill)                        cnt_d = '0;
         else if (accept[k])              cnt_d = load_dur;
         else if (tick && (cnt_q != '0))  cnt_d = cnt_q - ONE;
      end

      always_ff @(posedge clk) begin
         if (rst) cnt_q <= '0;
         else     cnt_q <= cnt_d;
      end

      assign live[k] = (cnt_q != '0);

`ifdef LED_BLINK_EN
      logic blink_q, blink_d;

      always_comb begin
         blink_d = blink_q;
         if (cnt_d == '0)    blink_d = 1'b0;
         else if (accept[k]) blink_d = led_blink;
      end

      always_ff @(posedge clk) begin
         if (rst) blink_q <= 1'b0;
         else     blink_q <= blink_d;
      end

      assign LEDR[k] = live[k] & (~blink_q | phase_q);
`else
      assign LEDR[k] = live[k];
`endif
   end

   always_comb begin
      active_d = '0;
      for (int i = 0; i < LED_COUNT; i++) active_d = active_d + ACT_W'(live[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_accepted_q <= 1'b0;
         req_rejected_q <= 1'b0;
         active_q       <= '0;
      end else begin
         req_accepted_q <= |accept;
         req_rejected_q <= led_request && !(|accept);
         active_q       <= active_d;
      end
   end

   assign req_accepted = req_accepted_q;
   assign req_rejected = req_rejected_q;
   assign active_count = active_q;

endmodule

// File: tb/tb_led_timer_bank.sv
// Directed bench: two instances (reject / reload retrigger policy) with one tick per clock.
module tb_led_timer_bank;

   localparam int LED_COUNT = 18;
   localparam int IDX_W     = 5;
   localparam int DUR_W     = 16;
   localparam int ACT_W     = $clog2(LED_COUNT + 1);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [IDX_W-1:0]     led_index = '0;
   logic                 led_request = 1'b0;
   logic [DUR_W-1:0]     led_dur = '0;
   logic                 led_cancel = 1'b0;
   logic                 cancel_all = 1'b0;
`ifdef LED_BLINK_EN
   logic                 led_blink = 1'b0;
`endif
   logic                 acc0, rej0, acc1, rej1;
   logic [ACT_W-1:0]     act0, act1;
   logic [LED_COUNT-1:0] led0, led1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   led_timer_bank #(
      .CLK_PERIOD_NS(1_000_000), .LED_COUNT(LED_COUNT), .IDX_W(IDX_W), .TICK_MS(1),
      .DUR_W(DUR_W), .DEFAULT_TICKS(8), .RETRIGGER(0)
   ) dut0 (
      .clk(clk), .rst(rst), .led_index(led_index), .led_request(led_request),
      .led_dur(led_dur), .led_cancel(led_cancel), .cancel_all(cancel_all),
      .req_accepted(acc0), .req_rejected(rej0), .active_count(act0),
`ifdef LED_BLINK_EN
      .led_blink(led_blink),
`endif
      .LEDR(led0)
   );

   led_timer_bank #(
      .CLK_PERIOD_NS(1_000_000), .LED_COUNT(LED_COUNT), .IDX_W(IDX_W), .TICK_MS(1),
      .DUR_W(DUR_W), .DEFAULT_TICKS(8), .RETRIGGER(1)
   ) dut1 (
      .clk(clk), .rst(rst), .led_index(led_index), .led_request(led_request),
      .led_dur(led_dur), .led_cancel(led_cancel), .cancel_all(cancel_all),
      .req_accepted(acc1), .req_rejected(rej1), .active_count(act1),
`ifdef LED_BLINK_EN
      .led_blink(led_blink),
`endif
      .LEDR(led1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      led_request = 1'b0;
      led_cancel  = 1'b0;
      cancel_all  = 1'b0;
   endtask

   task automatic req(input int idx, input int dur);
      led_index   = IDX_W'(idx);
      led_dur     = DUR_W'(dur);
      led_request = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int n, off0, off1;

      // 1: reset state, then a basic 4-tick request
      do_reset();
      check("rst_ledr", led0, 0);
      check("rst_active", act0, 0);
      check("rst_acc", acc0, 0);
      req(3, 4); step(); idle();
      check("t1_acc", acc0, 1);
      check("t1_active_lag", act0, 0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (led0[3]) n++;
         if (i == 1) begin
            check("t1_active_one", act0, 1);
            check("t1_acc_pulse", acc0, 0);
         end
         step();
      end
      check("t1_on_cycles", n, 4);
      check("t1_active_zero", act0, 0);

      // 2: re-request while active, reject vs reload
      do_reset();
      req(5, 10); step(); idle();
      step(); step();
      req(5, 10); step(); idle();
      check("t2_rej_r0", rej0, 1);
      check("t2_acc_r1", acc1, 1);
      off0 = 0; off1 = 0;
      for (int e = 5; e <= 20; e++) begin
         step();
         if (!led0[5] && off0 == 0) off0 = e;
         if (!led1[5] && off1 == 0) off1 = e;
      end
      check("t2_off_r0", off0 - 1, 10);
      check("t2_off_r1", off1 - 1, 13);

      // 3: out-of-range index and default duration
      do_reset();
      req(20, 5); step(); idle();
      check("t3_oob_rej", rej0, 1);
      check("t3_oob_acc", acc0, 0);
      check("t3_oob_ledr", led0, 0);
      req(0, 0); step(); idle();
      check("t3_def_acc", acc0, 1);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (led0[0]) n++;
         step();
      end
      check("t3_def_on", n, 8);

      // 4: cancel beats request; cancel_all
      do_reset();
      req(2, 5); led_cancel = 1'b1; step(); idle();
      check("t4_cancel_rej", rej0, 1);
      check("t4_cancel_led", led0[2], 0);
      for (int i = 0; i < 6; i++) begin
         req(i, 50); step();
      end
      idle(); step();
      check("t4_six_ledr", led0, 18'h3f);
      check("t4_six_active", act0, 6);
      cancel_all = 1'b1; step(); idle();
      check("t4_all_ledr", led0, 0);
      check("t4_all_active_lag", act0, 6);
      step();
      check("t4_all_active", act0, 0);

      // 5: re-request on the expiry cycle is accepted without a gap
      do_reset();
      req(7, 1); step(); idle();
      check("t5_first_led", led0[7], 1);
      req(7, 3); step(); idle();
      check("t5_expiry_acc", acc0, 1);
      check("t5_expiry_rej", rej0, 0);
      check("t5_no_gap", led0[7], 1);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (led0[7]) n++;
         step();
      end
      check("t5_on_cycles", n, 3);

      // 6: reset mid-timer aborts everything
      do_reset();
      req(1, 100); step();
      req(4, 100); step();
      req(9, 100); step();
      req(17, 100); step(); idle();
      step();
      check("t6_four_ledr", led0, 18'h20212);
      rst = 1'b1; req(10, 5); step(); idle(); rst = 1'b0;
      check("t6_rst_ledr", led0, 0);
      check("t6_rst_acc", acc0, 0);
      check("t6_rst_rej", rej0, 0);
      check("t6_rst_active", act0, 0);

`ifdef LED_BLINK_EN
      begin
         int hi, lo;
         do_reset();
         led_blink = 1'b1; req(0, 1000); step(); idle(); led_blink = 1'b0;
         hi = 0; lo = 0;
         for (int i = 0; i < 600; i++) begin
            if (led0[0]) hi++; else lo++;
            step();
         end
         check("t6_blink_hi", hi > 0, 1);
         check("t6_blink_lo", lo > 0, 1);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
